// File: rtl/popcount_pipe.sv
// popcount_pipe: pipelined popcount of d (in_valid) giving q/disp=2q-WIDTH/gt_half/eq_half/out_valid after L+1 clocks, plus running disparity acc (clr clears it); defining POPCOUNT_ACC_SAT_EN makes acc saturate and adds the acc_sat clamp pulse
module popcount_pipe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        d,
  input  logic                    in_valid,
  input  logic                    clr,
  output logic [CW-1:0]           q,
  output logic signed [CW:0]      disp,
  output logic                    gt_half,
  output logic                    eq_half,
  output logic                    out_valid,
`ifdef POPCOUNT_ACC_SAT_EN
  output logic                    acc_sat,
`endif
  output logic signed [ACC_W-1:0] acc
);
  localparam int L = $clog2(WIDTH);
  logic [L:0] v;
  always_ff @(posedge clk) v <= rst ? '0 : (L + 1)'({v, in_valid});
  for (genvar k = 0; k <= L; k++) begin : lvl
    localparam int N = (WIDTH + (1 << k) - 1) >> k;
    localparam int W = k + 1 < CW ? k + 1 : CW;
    logic [N-1:0][W-1:0] s, nx;
    if (k == 0) begin : g_in
      assign nx = d;
    end else begin : g_add
      localparam int P = (WIDTH + (1 << (k - 1)) - 1) >> (k - 1);
      for (genvar i = 0; i < N; i++) begin : g_e
        if (2 * i + 1 < P) begin : g_pair
          assign nx[i] = W'(lvl[k-1].s[2*i]) + W'(lvl[k-1].s[2*i+1]);
        end else begin : g_odd
          assign nx[i] = W'(lvl[k-1].s[2*i]);
        end
      end
    end
    always_ff @(posedge clk) s <= rst ? '0 : nx;
  end
  logic [CW-1:0] sum;
  logic [CW:0] twice;
  assign sum = lvl[L].s[0];
  assign twice = {sum, 1'b0};
  always_ff @(posedge clk)
    if (rst) begin
      q <= '0;
      disp <= '0;
      gt_half <= 1'b0;
      eq_half <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v[L];
      if (v[L]) begin
        q <= sum;
        disp <= $signed(twice - (CW + 1)'(WIDTH));
        gt_half <= twice > (CW + 1)'(WIDTH);
        eq_half <= twice == (CW + 1)'(WIDTH);
      end
    end
  logic signed [ACC_W-1:0] base, inc;
  assign base = clr ? '0 : acc;
  assign inc = out_valid ? ACC_W'(disp) : '0;
`ifdef POPCOUNT_ACC_SAT_EN
  logic signed [ACC_W:0] wide;
  logic ovf;
  assign wide = (ACC_W + 1)'(base) + (ACC_W + 1)'(inc);
  assign ovf = wide[ACC_W] ^ wide[ACC_W-1];
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      acc_sat <= 1'b0;
    end else begin
      acc <= ovf ? {wide[ACC_W], {(ACC_W - 1){~wide[ACC_W]}}} : wide[ACC_W-1:0];
      acc_sat <= ovf;
    end
`else
  always_ff @(posedge clk) acc <= rst ? '0 : base + inc;
`endif
endmodule

// File: tb/tb_popcount_pipe.sv
// tb_popcount_pipe: scoreboard bench for popcount_pipe at WIDTH 1/5/8/10 plus a narrow-accumulator instance
module tb_popcount_pipe;
  logic clk = 1'b0, rst = 1'b1, iv = 1'b0, clr = 1'b0;
  logic [9:0] dw = '0;
  always #5 clk = ~clk;

  logic [0:0] q1; logic signed [1:0] disp1; logic gt1, eq1, ov1; logic signed [7:0] acc1;
  logic [2:0] q5; logic signed [3:0] disp5; logic gt5, eq5, ov5; logic signed [7:0] acc5;
  logic [3:0] q8; logic signed [4:0] disp8; logic gt8, eq8, ov8; logic signed [7:0] acc8;
  logic [3:0] q10; logic signed [4:0] disp10; logic gt10, eq10, ov10; logic signed [7:0] acc10;
  logic [3:0] qa; logic signed [4:0] dispa; logic gta, eqa, ova; logic signed [4:0] acca;
`ifdef POPCOUNT_ACC_SAT_EN
  logic sat1, sat5, sat8, sat10, sata;
`endif

  popcount_pipe #(.WIDTH(1), .ACC_W(8)) u1 (.clk(clk), .rst(rst), .d(dw[0:0]), .in_valid(iv), .clr(clr),
    .q(q1), .disp(disp1), .gt_half(gt1), .eq_half(eq1), .out_valid(ov1),
`ifdef POPCOUNT_ACC_SAT_EN
    .acc_sat(sat1),
`endif
    .acc(acc1));
  popcount_pipe #(.WIDTH(5), .ACC_W(8)) u5 (.clk(clk), .rst(rst), .d(dw[4:0]), .in_valid(iv), .clr(clr),
    .q(q5), .disp(disp5), .gt_half(gt5), .eq_half(eq5), .out_valid(ov5),
`ifdef POPCOUNT_ACC_SAT_EN
    .acc_sat(sat5),
`endif
    .acc(acc5));
  popcount_pipe #(.WIDTH(8), .ACC_W(8)) u8 (.clk(clk), .rst(rst), .d(dw[7:0]), .in_valid(iv), .clr(clr),
    .q(q8), .disp(disp8), .gt_half(gt8), .eq_half(eq8), .out_valid(ov8),
`ifdef POPCOUNT_ACC_SAT_EN
    .acc_sat(sat8),
`endif
    .acc(acc8));
  popcount_pipe #(.WIDTH(10), .ACC_W(8)) u10 (.clk(clk), .rst(rst), .d(dw), .in_valid(iv), .clr(clr),
    .q(q10), .disp(disp10), .gt_half(gt10), .eq_half(eq10), .out_valid(ov10),
`ifdef POPCOUNT_ACC_SAT_EN
    .acc_sat(sat10),
`endif
    .acc(acc10));
  popcount_pipe #(.WIDTH(8), .ACC_W(5)) ua (.clk(clk), .rst(rst), .d(dw[7:0]), .in_valid(iv), .clr(clr),
    .q(qa), .disp(dispa), .gt_half(gta), .eq_half(eqa), .out_valid(ova),
`ifdef POPCOUNT_ACC_SAT_EN
    .acc_sat(sata),
`endif
    .acc(acca));

  typedef struct { int t; int q1, q5, q8, q10; int disp8; logic gt8, eq8; } rec_t;
  typedef struct { logic [7:0] d; int q; int disp; logic gt, eq; } vec_t;
  rec_t recs[$];
  vec_t vecs[8];
  int ptr[4], held[4];
  int hd8, ma, ma5, cyc, checks, failures;
  logic hg8, he8, mv, msat;

  task automatic cmp(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [9:0] w, input int q8e, input int d8e, input logic g, input logic e);
    rec_t r;
    r.t = cyc + 1;
    r.q1 = $countones(w[0]);
    r.q5 = $countones(w[4:0]);
    r.q8 = q8e;
    r.q10 = $countones(w);
    r.disp8 = d8e;
    r.gt8 = g;
    r.eq8 = e;
    recs.push_back(r);
  endtask

  task automatic chk(input int i, input string nm, input int lat, input logic v, input logic [3:0] qv, output logic ev);
    ev = 1'b0;
    if (ptr[i] < recs.size()) ev = recs[ptr[i]].t + lat == cyc;
    cmp({nm, ".out_valid"}, v, ev);
    if (ev) begin
      held[i] = i == 0 ? recs[ptr[i]].q1 : i == 1 ? recs[ptr[i]].q5 : i == 2 ? recs[ptr[i]].q8 : recs[ptr[i]].q10;
      if (i == 2) begin
        hd8 = recs[ptr[i]].disp8;
        hg8 = recs[ptr[i]].gt8;
        he8 = recs[ptr[i]].eq8;
      end
      ptr[i]++;
    end
    cmp({nm, ".q"}, qv, held[i]);
  endtask

  task automatic step(input logic [9:0] w, input logic v, input logic c);
    int n, n5;
    logic e;
    dw = w;
    iv = v;
    clr = c;
    n = (c ? 0 : ma) + (mv ? hd8 : 0);
    n5 = (c ? 0 : ma5) + (mv ? hd8 : 0);
    ma = rst ? 0 : ((n + 128) & 255) - 128;
`ifdef POPCOUNT_ACC_SAT_EN
    msat = !rst && (n5 > 15 || n5 < -16);
    ma5 = rst ? 0 : n5 > 15 ? 15 : n5 < -16 ? -16 : n5;
`else
    ma5 = rst ? 0 : ((n5 + 16) & 31) - 16;
`endif
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        ptr[i] = recs.size();
        held[i] = 0;
      end
      hd8 = 0;
      hg8 = 1'b0;
      he8 = 1'b0;
    end
    chk(0, "w1", 1, ov1, 4'(q1), e);
    chk(1, "w5", 4, ov5, 4'(q5), e);
    chk(3, "w10", 5, ov10, q10, e);
    chk(2, "w8", 4, ov8, q8, e);
    mv = e;
    cmp("w8.disp", disp8, hd8);
    cmp("w8.gt_half", gt8, hg8);
    cmp("w8.eq_half", eq8, he8);
    cmp("w8.acc", acc8, ma);
    cmp("acc5.acc", acca, ma5);
`ifdef POPCOUNT_ACC_SAT_EN
    cmp("acc5.acc_sat", sata, msat);
`endif
  endtask

  task automatic word(input logic [9:0] w, input logic c);
    int n;
    n = $countones(w[7:0]);
    push(w, n, 2 * n - 8, 2 * n > 8, 2 * n == 8);
    step(w, 1'b1, c);
  endtask

  initial begin
    logic [9:0] w;
    vecs[0] = '{8'h00, 0, -8, 1'b0, 1'b0};
    vecs[1] = '{8'h0F, 4, 0, 1'b0, 1'b1};
    vecs[2] = '{8'hF7, 7, 6, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8, 8, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 1, -6, 1'b0, 1'b0};
    vecs[5] = '{8'h7E, 6, 4, 1'b1, 1'b0};
    vecs[6] = '{8'h18, 2, -4, 1'b0, 1'b0};
    vecs[7] = '{8'hAA, 4, 0, 1'b0, 1'b1};
    repeat (3) step(10'h3FF, 1'b1, 1'b0);
    rst = 1'b0;
    word(10'h0FF, 1'b0);
    repeat (6) step('0, 1'b0, 1'b0);
    cmp("single.acc", acc8, 8);
    step('0, 1'b0, 1'b1);
    cmp("clr_alone.acc", acc8, 0);
    for (int j = 0; j < 8; j++) begin
      push({2'b00, vecs[j].d}, vecs[j].q, vecs[j].disp, vecs[j].gt, vecs[j].eq);
      step({2'b00, vecs[j].d}, 1'b1, 1'b0);
    end
    repeat (6) step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    word(10'h000, 1'b0);
    word(10'h0F7, 1'b0);
    repeat (4) step('0, 1'b0, 1'b0);
    cmp("collision.pre_acc", acc8, -8);
    step('0, 1'b0, 1'b1);
    cmp("collision.acc", acc8, 6);
    repeat (3) word(10'h0FF, 1'b0);
    rst = 1'b1;
    step('0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (6) step('0, 1'b0, 1'b0);
    cmp("rst_mid.acc", acc8, 0);
    repeat (4) word(10'h0FF, 1'b0);
    repeat (3) step('0, 1'b0, 1'b0);
`ifdef POPCOUNT_ACC_SAT_EN
    cmp("overflow.acc", acca, 15);
`else
    cmp("overflow.acc", acca, -16);
`endif
    repeat (4) step('0, 1'b0, 1'b0);
    repeat (120) begin
      w = 10'($urandom);
      if ($urandom_range(0, 4) != 0) word(w, $urandom_range(0, 19) == 0);
      else step(w, 1'b0, $urandom_range(0, 19) == 0);
    end
    repeat (8) step('0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
